conv_engine: RTL and testbench
==============================

# conv_engine

Streaming 2-D convolution engine, the parametrised successor to the fixed-stride TPU convolution datapath. It accepts a CONV_DIM×CONV_DIM kernel and a MATRIX_DIM×MATRIX_DIM matrix over a valid/ready input stream. It then computes every valid-window dot product at a run-time stride, in signed or unsigned arithmetic, and emits results over a valid/ready output stream with backpressure. It sits between the host data loader and the result buffer.

## Interface

- DATA_WIDTH, 8, element width of kernel and matrix data
- MATRIX_DIM, 16, matrix side length (≥ CONV_DIM)
- CONV_DIM, 3, kernel side length (≥ 2)
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(CONV_DIM*CONV_DIM), accumulator/result width

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a job; sampled only in IDLE
- stride  in  2  window step; 0 treated as 1; latched at start
- signed_mode  in  1  1 = two's-complement operands; latched at start
- reuse_kernel  in  1  1 = skip kernel load, keep stored kernel; latched at start
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts a beat
- in_data  in  DATA_WIDTH  kernel or matrix element
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_WIDTH  convolution result
- out_last  out  1  marks final result of the job
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last result handshake

## Operation

- States: IDLE → LOAD_K → LOAD_M → COMPUTE ⇄ OUT → DONE → IDLE.
- IDLE: start=1 latches stride, signed_mode and reuse_kernel. It goes to LOAD_M if reuse_kernel=1, otherwise to LOAD_K. start is ignored outside IDLE.
- LOAD_K: in_ready=1. CONV_DIM² beats, row-major: beat b writes K[b/CONV_DIM][b%CONV_DIM]. After the last beat the engine goes to LOAD_M.
- LOAD_M: in_ready=1. MATRIX_DIM² beats, row-major into M. After the last beat the engine goes to COMPUTE.
- A beat transfers only when in_valid&in_ready. In_valid gaps stall loading without error.
- Window count per axis: OUT_N = (MATRIX_DIM−CONV_DIM)/s + 1, where s is the effective stride. Windows are issued row-major.
- Result: out[r][c] = Σ_{i,j} K[i][j]·M[r·s+i][c·s+j]. This is correlation; the kernel is not flipped.
- COMPUTE: exactly one product per cycle for CONV_DIM² cycles, accumulated from 0.
- Arithmetic:
  - Operands are zero-extended (unsigned) or sign-extended (signed_mode) before multiplication.
  - Each product is extended to ACC_WIDTH, and the sum wraps modulo 2^ACC_WIDTH.
  - The default ACC_WIDTH cannot overflow.
- OUT: out_valid=1. out_data and out_last are held stable until out_ready.
  - On handshake, the engine goes to COMPUTE for the next window, or to DONE after the last one.
- DONE: done=1 for one cycle, then IDLE.
- Kernel storage persists across jobs. With reuse_kernel=1 and no prior load, the kernel is all zeros and every result is 0.
- Matrix storage is overwritten each job.

## Timing

- Reset (rst=0, asynchronous) puts the engine in IDLE and clears kernel, matrix and accumulator storage.
  - in_ready, out_valid, out_data, out_last, busy and done are all 0.
- Reset mid-job aborts immediately; no done pulse and no further out_valid.
- busy rises the cycle after the start sample and falls in the cycle after DONE.
- in_ready goes high the cycle after start is sampled.
- The last matrix beat at cycle t gives the first COMPUTE cycle at t+1 and out_valid at t+1+CONV_DIM².
- With out_ready held at 1, the engine produces one result every CONV_DIM²+1 cycles.
- The last output handshake at cycle t gives done=1 at t+1 and busy=0 at t+2.
- in_ready=0 in COMPUTE, OUT, DONE and IDLE.
- out_valid=0 outside OUT.

## Test plan

- Centre-tap kernel with stride 0, unsigned:
  - Stimulus: K[1][1]=1, others 0; M[r][c]=(16r+c) mod 256.
  - Required: 196 results with out[r][c]=M[r+1][c+1]; out_last only on the 196th; done exactly once.
- Unsigned saturation inputs: all-ones kernel, all-255 matrix.
  - Required: every result is 585225 (0x8EE09).
- Signed mode:
  - K=0x80, M=0x80 everywhere → 147456.
  - K=0x80, M=0x7F everywhere → −146304, i.e. 0xDC480 in 20 bits.
- Stride sweep, each checked for count and window origin:
  - stride 2 → 49 results with windows at row/col 0,2,…,12.
  - stride 3 → 25 results with windows at 0,3,…,12.
- Backpressure and input gaps:
  - Stimulus: random in_valid gaps; out_ready low for 10 cycles mid-job.
  - Required: out_data and out_last stable while stalled; no result lost or duplicated; results match the model.
- Reuse and reset:
  - A second start with reuse_kernel=1 takes its first beat into M[0][0] and produces results using the prior kernel.
  - rst pulsed low mid-COMPUTE: all outputs read 0 and done never pulses; a new job then completes correctly.

Source files
------------

// File: rtl/conv_engine.sv
// conv_engine: streaming 2-D correlation engine with run-time stride, signed/unsigned
// operands and valid/ready input and output streams.
module conv_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int MATRIX_DIM = 16,
   parameter int CONV_DIM   = 3,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(CONV_DIM*CONV_DIM)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            stride,
   input  logic                  signed_mode,
   input  logic                  reuse_kernel,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);
   localparam int KN   = CONV_DIM*CONV_DIM;
   localparam int MN   = MATRIX_DIM*MATRIX_DIM;
   localparam int KW   = $clog2(KN);
   localparam int MW   = $clog2(MN);
   localparam int TW   = $clog2(CONV_DIM);
   localparam int WW   = $clog2(MATRIX_DIM+4);
   localparam int LAST = MATRIX_DIM-CONV_DIM;

   typedef enum logic [2:0] {IDLE, LOAD_K, LOAD_M, COMPUTE, OUT, DONE} state_t;
   state_t state, next;

   logic [DATA_WIDTH-1:0] k_mem [KN];
   logic [DATA_WIDTH-1:0] m_mem [MN];
   logic [MW-1:0]         cnt;
   logic [TW-1:0]         ti, tj;
   logic [WW-1:0]         wr, wc;
   logic [1:0]            s;
   logic                  sgn;
   logic [ACC_WIDTH-1:0]  acc, k_ext, m_ext;
   logic [DATA_WIDTH-1:0] k_val, m_val;
   logic                  beat, last_beat, tj_end, last_tap, row_end, col_end;

   assign in_ready  = state == LOAD_K || state == LOAD_M;
   assign out_valid = state == OUT;
   assign busy      = state != IDLE;
   assign done      = state == DONE;
   assign out_data  = acc;
   assign beat      = in_valid && in_ready;
   assign last_beat = state == LOAD_K ? cnt == MW'(KN-1) : cnt == MW'(MN-1);
   assign tj_end    = tj == TW'(CONV_DIM-1);
   assign last_tap  = tj_end && ti == TW'(CONV_DIM-1);
   // a window is the last on its axis when the next step would run past the matrix edge
   assign col_end   = int'(wc) + int'(s) > LAST;
   assign row_end   = int'(wr) + int'(s) > LAST;
   assign out_last  = out_valid && row_end && col_end;
   assign k_val     = k_mem[KW'(int'(ti)*CONV_DIM + int'(tj))];
   assign m_val     = m_mem[MW'((int'(wr)+int'(ti))*MATRIX_DIM + int'(wc) + int'(tj))];
   assign k_ext     = {{(ACC_WIDTH-DATA_WIDTH){sgn & k_val[DATA_WIDTH-1]}}, k_val};
   assign m_ext     = {{(ACC_WIDTH-DATA_WIDTH){sgn & m_val[DATA_WIDTH-1]}}, m_val};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         IDLE:    if (start) next = reuse_kernel ? LOAD_M : LOAD_K;
         LOAD_K:  if (beat && last_beat) next = LOAD_M;
         LOAD_M:  if (beat && last_beat) next = COMPUTE;
         COMPUTE: if (last_tap) next = OUT;
         OUT:     if (out_ready) next = row_end && col_end ? DONE : COMPUTE;
         DONE:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < KN; i++) k_mem[i] <= '0;
         for (int i = 0; i < MN; i++) m_mem[i] <= '0;
         cnt <= '0;
         ti  <= '0;
         tj  <= '0;
         wr  <= '0;
         wc  <= '0;
         s   <= 2'd1;
         sgn <= 1'b0;
         acc <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               s   <= stride == 2'd0 ? 2'd1 : stride;
               sgn <= signed_mode;
               cnt <= '0;
            end
            LOAD_K: if (beat) begin
               k_mem[KW'(cnt)] <= in_data;
               cnt <= last_beat ? '0 : cnt + 1'b1;
            end
            LOAD_M: if (beat) begin
               m_mem[cnt] <= in_data;
               cnt <= last_beat ? '0 : cnt + 1'b1;
               if (last_beat) begin
                  acc <= '0;
                  ti  <= '0;
                  tj  <= '0;
                  wr  <= '0;
                  wc  <= '0;
               end
            end
            COMPUTE: begin
               acc <= acc + k_ext * m_ext;
               tj  <= tj_end ? '0 : tj + 1'b1;
               ti  <= tj_end ? (last_tap ? '0 : ti + 1'b1) : ti;
            end
            OUT: if (out_ready) begin
               acc <= '0;
               wc  <= col_end ? '0 : wc + WW'(s);
               wr  <= col_end ? wr + WW'(s) : wr;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: randomized directed-sequence bench for conv_engine with a plain-arithmetic
// correlation model.
module tb_conv_engine;
   localparam int DW = 8, MD = 16, CD = 3, AW = 2*DW + $clog2(CD*CD);
   logic clk = 0, rst = 0, start = 0, signed_mode = 0, reuse_kernel = 0, in_valid = 0, out_ready = 0;
   logic [1:0] stride = 0;
   logic [DW-1:0] in_data = '0;
   logic in_ready, out_valid, out_last, busy, done;
   logic [AW-1:0] out_data;
   int compared = 0, mismatched = 0;
   int ref_k [CD*CD];
   int ref_m [MD*MD];
   longint exp_q [$];
   longint got_q [$];

   always #5 clk = ~clk;

   conv_engine dut (.clk(clk), .rst(rst), .start(start), .stride(stride), .signed_mode(signed_mode),
      .reuse_kernel(reuse_kernel), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic build_exp(input int st, input bit sg);
      int se = st == 0 ? 1 : st;
      int n = (MD - CD) / se + 1;
      exp_q.delete();
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++) begin
            longint sum = 0;
            for (int i = 0; i < CD; i++)
               for (int j = 0; j < CD; j++) begin
                  longint kv = ref_k[i*CD+j];
                  longint mv = ref_m[(r*se+i)*MD + c*se + j];
                  if (sg && kv > 127) kv -= 256;
                  if (sg && mv > 127) mv -= 256;
                  sum += kv * mv;
               end
            exp_q.push_back(sum & ((longint'(1) << AW) - 1));
         end
   endtask

   task automatic run_job(input string tag, input int st, input bit sg, input bit reuse,
                          input int gap, input bit stall_mid, input bit full_rate);
      logic [DW-1:0] stream [$];
      logic [AW-1:0] held = '0;
      logic held_last = 0, pend = 0, stalled = 0;
      int idx = 0, nres, hs = 0, last_hs = -100, first_ov = -1, beat_end = -1, cyc = 0, stall_left = 0, done_n = 0;
      if (!reuse) foreach (ref_k[i]) stream.push_back(DW'(ref_k[i]));
      foreach (ref_m[i]) stream.push_back(DW'(ref_m[i]));
      build_exp(st, sg);
      nres = exp_q.size();
      got_q.delete();
      @(negedge clk);
      start = 1; stride = 2'(st); signed_mode = sg; reuse_kernel = reuse;
      @(negedge clk);
      start = 0;
      chk({tag, " busy_after_start"}, busy, 1);
      chk({tag, " in_ready_after_start"}, in_ready, 1);
      while (done_n == 0 && cyc < 20000) begin
         in_valid = idx < stream.size() && $urandom_range(99) >= gap;
         in_data = in_valid ? stream[idx] : '0;
         if (in_valid && in_ready) begin
            idx++;
            if (idx == stream.size()) beat_end = cyc;
         end
         if (pend) begin
            chk({tag, " stall_valid"}, out_valid, 1);
            chk({tag, " stall_data"}, out_data, held);
            chk({tag, " stall_last"}, out_last, held_last);
         end
         if (out_valid && first_ov < 0) first_ov = cyc;
         if (stall_left > 0) begin
            out_ready = 0;
            stall_left--;
         end else if (stall_mid && !stalled && out_valid && hs == nres / 2) begin
            out_ready = 0;
            stall_left = 9;
            stalled = 1;
         end else out_ready = full_rate ? 1'b1 : $urandom_range(3) != 0;
         pend = out_valid && !out_ready;
         held = out_data;
         held_last = out_last;
         if (out_valid && out_ready) begin
            got_q.push_back(longint'(out_data));
            chk({tag, " result_in_range"}, hs < nres, 1);
            if (hs < nres) chk($sformatf("%s result[%0d]", tag, hs), out_data, exp_q[hs]);
            chk($sformatf("%s last[%0d]", tag, hs), out_last, hs == nres - 1);
            if (full_rate && hs > 0) chk({tag, " result_spacing"}, cyc - last_hs, CD*CD + 1);
            last_hs = cyc;
            hs++;
         end
         @(negedge clk);
         cyc++;
         if (done) begin
            done_n++;
            chk({tag, " done_timing"}, cyc, last_hs + 1);
         end
      end
      in_valid = 0;
      chk({tag, " done_seen"}, done_n, 1);
      chk({tag, " result_count"}, hs, nres);
      chk({tag, " first_out_latency"}, first_ov - beat_end, CD*CD + 1);
      @(negedge clk);
      chk({tag, " done_one_cycle"}, done, 0);
      chk({tag, " busy_low"}, busy, 0);
   endtask

   initial begin
      int bad = 0;
      foreach (ref_k[i]) ref_k[i] = 0;
      repeat (2) @(negedge clk);
      chk("reset in_ready", in_ready, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_data", out_data, 0);
      chk("reset out_last", out_last, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      rst = 1;

      foreach (ref_k[i]) ref_k[i] = i == 4 ? 1 : 0;
      foreach (ref_m[i]) ref_m[i] = ((i / MD) * 16 + i % MD) % 256;
      run_job("centre", 0, 0, 0, 0, 0, 1);
      chk("centre count", got_q.size(), 196);
      chk("centre first", got_q[0], 17);
      chk("centre final", got_q[195], 238);

      foreach (ref_k[i]) ref_k[i] = 255;
      foreach (ref_m[i]) ref_m[i] = 255;
      run_job("sat", 1, 0, 0, 30, 0, 0);
      chk("sat value", got_q[0], 585225);

      foreach (ref_k[i]) ref_k[i] = 128;
      foreach (ref_m[i]) ref_m[i] = 128;
      run_job("sgn80", 1, 1, 0, 20, 0, 0);
      chk("sgn80 value", got_q[0], 147456);
      foreach (ref_m[i]) ref_m[i] = 127;
      run_job("sgn7f", 1, 1, 0, 20, 0, 0);
      chk("sgn7f value", got_q[0], 'hDC480);

      foreach (ref_k[i]) ref_k[i] = $urandom_range(255);
      foreach (ref_m[i]) ref_m[i] = $urandom_range(255);
      run_job("stride2", 2, 0, 0, 25, 0, 0);
      chk("stride2 count", got_q.size(), 49);
      foreach (ref_k[i]) ref_k[i] = $urandom_range(255);
      foreach (ref_m[i]) ref_m[i] = $urandom_range(255);
      run_job("stride3", 3, 1, 0, 40, 1, 0);
      chk("stride3 count", got_q.size(), 25);

      foreach (ref_m[i]) ref_m[i] = $urandom_range(255);
      run_job("reuse", 1, 1, 1, 10, 1, 0);

      foreach (ref_k[i]) ref_k[i] = $urandom_range(255);
      foreach (ref_m[i]) ref_m[i] = $urandom_range(255);
      @(negedge clk);
      start = 1; stride = 1; signed_mode = 0; reuse_kernel = 0;
      @(negedge clk);
      start = 0;
      for (int i = 0; i < CD*CD + MD*MD && in_ready; i++) begin
         in_valid = 1;
         in_data = DW'(i < CD*CD ? ref_k[i] : ref_m[i - CD*CD]);
         @(negedge clk);
      end
      in_valid = 0;
      repeat (3) @(negedge clk);
      chk("abort in_compute", {busy, in_ready, out_valid}, 3'b100);
      #2 rst = 0;
      #1;
      chk("abort in_ready", in_ready, 0);
      chk("abort out_valid", out_valid, 0);
      chk("abort out_data", out_data, 0);
      chk("abort out_last", out_last, 0);
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      @(negedge clk);
      rst = 1;
      repeat (40) begin
         @(negedge clk);
         if (done || out_valid || busy) bad++;
      end
      chk("abort quiet", bad, 0);

      foreach (ref_k[i]) ref_k[i] = 0;
      foreach (ref_m[i]) ref_m[i] = $urandom_range(255);
      run_job("zero_kernel", 3, 0, 1, 10, 0, 0);
      chk("zero_kernel value", got_q[0], 0);

      foreach (ref_k[i]) ref_k[i] = $urandom_range(255);
      foreach (ref_m[i]) ref_m[i] = $urandom_range(255);
      run_job("after_reset", 2, 1, 0, 15, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
